// File: rtl/snake_pkg.sv
// Shared SnakeWars link definitions: byte type codes and the heartbeat payload.
// Each link byte is {type[7:6], payload[5:0]}.
package snake_pkg;

    typedef enum logic [1:0] {
        LNK_START  = 2'b00,
        LNK_SEED_X = 2'b01,
        LNK_SEED_Y = 2'b10,
        LNK_HB     = 2'b11
    } link_type_t;

    localparam logic [5:0] HB_PAYLOAD = 6'h2A;

    function automatic logic [7:0] link_byte(input link_type_t kind, input logic [5:0] payload);
        return {kind, payload};
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid/frame_err strobes.
// A start edge that is high again at half-bit is treated as a glitch.
module uart_rx #(
    parameter int CLKS_PER_BIT = 651
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t     state;
    logic [1:0]    sync_q;
    logic          rx_prev;
    logic [BW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= R_IDLE;
            sync_q    <= 2'b11;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rxd};
            rx_prev   <= sync_q[1];
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                R_IDLE: begin
                    if (rx_prev && !sync_q[1]) begin
                        state <= R_START;
                        cnt   <= '0;
                    end
                end
                R_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync_q[1] ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {sync_q[1], shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= R_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= R_IDLE;
                        if (sync_q[1]) begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/link_ctrl.sv
// SnakeWars board-to-board link: TX request capture, arbitration and 8N1 transmitter,
// RX byte decode into seeds/start, heartbeat and silence timers.
module link_ctrl
    import snake_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 651,
    parameter int HB_CYCLES      = 750_000,
    parameter int TIMEOUT_CYCLES = 7_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link_en,
    input  logic       uart_rxd,
    output logic       uart_txd,
    input  logic       start_req,
    input  logic [5:0] seed_x_out,
    input  logic [5:0] seed_y_out,
    input  logic       seed_rdy,
    output logic [5:0] seed_x_in,
    output logic [5:0] seed_y_in,
    output logic       seed_valid,
    output logic       start_game,
    output logic       con_error,
    output logic       tx_busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int HW = $clog2(HB_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [HW-1:0] HB_LAST  = HW'(HB_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {SEL_NONE, SEL_Y, SEL_START, SEL_X, SEL_HB} tx_sel_t;

    tx_state_t     tx_state;
    logic [BW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          txd_q;
    logic          seed_pend, start_pend, y_pend;
    logic [5:0]    sx_buf, sy_buf, y_byte;
    logic [HW-1:0] hb_cnt;
    tx_sel_t       sel;
    logic [7:0]    sel_byte;

    // The second half of a pair outranks START so a pair is never split.
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        sel      = SEL_NONE;
        sel_byte = 8'h00;
        if (tx_state == TX_IDLE && link_en) begin
            if (y_pend) begin
                sel      = SEL_Y;
                sel_byte = link_byte(LNK_SEED_Y, y_byte);
            end else if (start_pend) begin
                sel      = SEL_START;
                sel_byte = link_byte(LNK_START, 6'd0);
            end else if (seed_pend) begin
                sel      = SEL_X;
                sel_byte = link_byte(LNK_SEED_X, sx_buf);
            end else if (hb_cnt == HB_LAST) begin
                sel      = SEL_HB;
                sel_byte = link_byte(LNK_HB, HB_PAYLOAD);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_pend  <= 1'b0;
            start_pend <= 1'b0;
            y_pend     <= 1'b0;
            sx_buf     <= '0;
            sy_buf     <= '0;
            y_byte     <= '0;
            hb_cnt     <= '0;
        end else begin
            if (seed_rdy) begin
                sx_buf    <= seed_x_out;
                sy_buf    <= seed_y_out;
                seed_pend <= 1'b1;
            end else if (sel == SEL_X) begin
                seed_pend <= 1'b0;
            end
            // Y is frozen at launch of X, so a later seed_rdy only refills the buffer.
            if (sel == SEL_X) begin
                y_pend <= 1'b1;
                y_byte <= sy_buf;
            end else if (sel == SEL_Y) begin
                y_pend <= 1'b0;
            end
            if (start_req) begin
                start_pend <= 1'b1;
            end else if (sel == SEL_START) begin
                start_pend <= 1'b0;
            end
            if (sel != SEL_NONE || !link_en) begin
                hb_cnt <= '0;
            end else if (tx_state == TX_IDLE && hb_cnt != HB_LAST) begin
                hb_cnt <= hb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd_q    <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (sel != SEL_NONE) begin
                        tx_state <= TX_START;
                        tx_shift <= sel_byte;
                        tx_cnt   <= '0;
                        txd_q    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        txd_q    <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            txd_q    <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            txd_q    <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = (tx_state != TX_IDLE) | seed_pend | start_pend | y_pend;

    logic [7:0]    rx_data;
    logic          rx_valid, rx_frame_err;
    logic [5:0]    x_hold;
    logic          x_ok;
    logic [TW-1:0] sil_cnt;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rxd       (uart_rxd),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_x_in  <= '0;
            seed_y_in  <= '0;
            seed_valid <= 1'b0;
            start_game <= 1'b0;
            x_hold     <= '0;
            x_ok       <= 1'b0;
        end else begin
            seed_valid <= 1'b0;
            start_game <= 1'b0;
            if (rx_valid) begin
                case (link_type_t'(rx_data[7:6]))
                    LNK_START:  start_game <= 1'b1;
                    LNK_SEED_X: begin
                        x_hold <= rx_data[5:0];
                        x_ok   <= 1'b1;
                    end
                    LNK_SEED_Y: begin
                        if (x_ok) begin
                            seed_x_in  <= x_hold;
                            seed_y_in  <= rx_data[5:0];
                            seed_valid <= 1'b1;
                            x_ok       <= 1'b0;
                        end
                    end
                    LNK_HB:     ;
                endcase
            end else if (rx_frame_err) begin
                // A corrupted byte may have been the partner Y, so the held X is no longer trusted.
                x_ok <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sil_cnt   <= '0;
            con_error <= 1'b0;
        end else if (!link_en) begin
            sil_cnt   <= '0;
            con_error <= 1'b0;
        end else if (rx_valid) begin
            sil_cnt <= '0;
        end else if (sil_cnt == TO_LAST) begin
            con_error <= 1'b1;
        end else begin
            sil_cnt <= sil_cnt + 1'b1;
        end
    end

endmodule
